// File: rtl/reg_status_tbl.sv
// Register status table: maps each architectural register to the RS tag that will produce it.
// Latency: table updates land 1 cycle after the edge; Qj/Qk/pending_cnt are zero-latency reads.
// Backpressure: issue_ready drops only during flush or reset; CDB broadcasts are always accepted.
//
// Ports:
//   clk, rst_n         clock; reset is asynchronous and active-high despite the _n name
//   issue_valid/ready  rename handshake; issue_rd <- issue_tag when both are high at an edge
//   issue_rd/tag       destination register and producing reservation-station tag
//   rs1, rs2 -> Qj, Qk source lookups; a zero tag means the operand is ready
//   cdb_valid/tag      completion broadcast; clears every entry holding cdb_tag
//   flush              squash all renames at the next edge
//   pending_cnt        number of registers still waiting on a producer
module reg_status_tbl #(
  parameter int NUM_REGS = 32,
  parameter int TAG_W    = 4,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NUM_REGS),
  localparam int CW      = $clog2(NUM_REGS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [AW-1:0]    issue_rd,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  output logic [TAG_W-1:0] Qj,
  output logic [TAG_W-1:0] Qk,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic             flush,
  output logic [CW-1:0]    pending_cnt
);

  localparam logic BYP = (BYPASS != 0);

  // Entry 0 is cleared on reset and never written afterwards, so it always reads 0.
  logic [TAG_W-1:0] tbl [NUM_REGS];

  logic             do_rename;
  logic             cdb_hit;
  logic [TAG_W-1:0] raw_j;
  logic [TAG_W-1:0] raw_k;
  logic [CW-1:0]    cnt;

  assign issue_ready = !flush && !rst_n;
  assign do_rename   = issue_valid && issue_ready;
  // Tag 0 means "no producer", so a broadcast of tag 0 must never match anything.
  assign cdb_hit     = cdb_valid && (cdb_tag != '0);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) tbl[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_REGS; i++) tbl[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        // Rename is checked first: a new producer outranks a completion of the old one.
        if (do_rename && (issue_rd == AW'(i))) begin
          tbl[i] <= issue_tag;
        end else if (cdb_hit && (tbl[i] == cdb_tag)) begin
          tbl[i] <= '0;
        end
      end
    end
  end

  // Reads see the current table only; a same-cycle rename is not forwarded,
  // but a same-cycle completion is (when BYPASS is enabled).
  assign raw_j = tbl[rs1];
  assign raw_k = tbl[rs2];
  assign Qj    = (BYP && cdb_hit && (raw_j == cdb_tag)) ? '0 : raw_j;
  assign Qk    = (BYP && cdb_hit && (raw_k == cdb_tag)) ? '0 : raw_k;

  always_comb begin
    cnt = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (tbl[i] != '0) cnt = cnt + CW'(1);
    end
  end
  assign pending_cnt = cnt;

endmodule

// File: tb/tb_reg_status_tbl.sv
// Bench for reg_status_tbl: directed scenarios followed by randomized traffic against a reference model.
// Latency: model state advances at each rising edge; outputs are sampled 1-2 time units after input changes.
// Backpressure: the model accepts a rename only when neither flush nor reset is active.
module tb_reg_status_tbl;
  localparam int NR = 32;
  localparam int TW = 4;
  localparam int AW = 5;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          issue_valid;
  logic          issue_ready;
  logic [AW-1:0] issue_rd;
  logic [TW-1:0] issue_tag;
  logic [AW-1:0] rs1, rs2;
  logic [TW-1:0] Qj, Qk;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic          flush;
  logic [CW-1:0] pending_cnt;

  int n_pass = 0;
  int n_tot  = 0;
  int mdl [NR];

  always #5 clk = ~clk;

  reg_status_tbl #(.NUM_REGS(NR), .TAG_W(TW), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rd(issue_rd), .issue_tag(issue_tag),
    .rs1(rs1), .rs2(rs2), .Qj(Qj), .Qk(Qk),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .flush(flush), .pending_cnt(pending_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic int exp_read(input int idx);
    int v;
    v = mdl[idx];
    if (cdb_valid && cdb_tag != 0 && v == int'(cdb_tag)) v = 0;
    return v;
  endfunction

  function automatic int exp_pending();
    int c;
    c = 0;
    for (int r = 1; r < NR; r++) if (mdl[r] != 0) c++;
    return c;
  endfunction

  // Compare all combinational outputs with the model for the current inputs.
  task automatic check_all(input string tag);
    #1;
    chk({tag, "_qj"}, 32'(Qj), 32'(exp_read(int'(rs1))));
    chk({tag, "_qk"}, 32'(Qk), 32'(exp_read(int'(rs2))));
    chk({tag, "_pend"}, 32'(pending_cnt), 32'(exp_pending()));
    chk({tag, "_rdy"}, 32'(issue_ready), 32'(!flush && !rst_n));
  endtask

  // Advance one edge; the model consumes the inputs held across that edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      if (flush) begin
        for (int r = 0; r < NR; r++) mdl[r] = 0;
      end else begin
        if (cdb_valid && cdb_tag != 0)
          for (int r = 0; r < NR; r++) if (mdl[r] == int'(cdb_tag)) mdl[r] = 0;
        if (issue_valid && issue_rd != 0) mdl[issue_rd] = int'(issue_tag);
      end
    end
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; cdb_valid = 0; flush = 0;
  endtask

  task automatic rename(input int rd, input int tg);
    issue_valid = 1; issue_rd = AW'(rd); issue_tag = TW'(tg);
    tick();
    issue_valid = 0;
  endtask

  initial begin
    for (int r = 0; r < NR; r++) mdl[r] = 0;
    idle();
    issue_rd = 0; issue_tag = 0; rs1 = 0; rs2 = 0; cdb_tag = 0;
    rst_n = 0;
    #1 rst_n = 1;
    repeat (2) tick();
    check_all("reset");
    chk("reset_rdy0", 32'(issue_ready), 32'd0);
    #2 rst_n = 0;

    // First rename right after reset release; r5 <- 3
    rename(5, 3);
    rs1 = 5; rs2 = 0;
    check_all("r5_tag3");
    chk("r5_qj_const", 32'(Qj), 32'd3);
    chk("r5_pend_const", 32'(pending_cnt), 32'd1);

    // Same tag in two entries, broadcast with bypass
    rename(9, 3);
    cdb_valid = 1; cdb_tag = 3; rs1 = 9; rs2 = 5;
    check_all("cdb_bypass");
    chk("cdb_bypass_qj", 32'(Qj), 32'd0);
    chk("cdb_bypass_pend", 32'(pending_cnt), 32'd2);
    tick();
    cdb_valid = 0;
    check_all("cdb_after");
    chk("cdb_after_pend", 32'(pending_cnt), 32'd0);

    // Rename beats a matching CDB clear on the same entry
    rename(7, 2);
    issue_valid = 1; issue_rd = 7; issue_tag = 6; cdb_valid = 1; cdb_tag = 2;
    tick();
    idle();
    rs1 = 7;
    check_all("rename_wins");
    chk("rename_wins_qj", 32'(Qj), 32'd6);

    // Same-cycle rename is not visible on the read port
    rename(4, 1);
    issue_valid = 1; issue_rd = 4; issue_tag = 5; rs1 = 4;
    check_all("no_fwd");
    chk("no_fwd_qj_old", 32'(Qj), 32'd1);
    tick();
    issue_valid = 0;
    check_all("no_fwd_next");
    chk("no_fwd_qj_new", 32'(Qj), 32'd5);

    // Fill every register, then flush together with a rename
    for (int r = 1; r < NR; r++) rename(r, (r % 15) + 1);
    check_all("filled");
    chk("filled_pend", 32'(pending_cnt), 32'd31);
    flush = 1; issue_valid = 1; issue_rd = 2; issue_tag = 7;
    check_all("flush_cyc");
    chk("flush_rdy", 32'(issue_ready), 32'd0);
    tick();
    idle();
    for (int r = 0; r < NR; r++) begin
      rs1 = AW'(r); rs2 = AW'(NR - 1 - r);
      check_all("post_flush");
    end
    chk("post_flush_pend", 32'(pending_cnt), 32'd0);

    // Renaming r0 has no effect
    rename(3, 2);
    rename(0, 4);
    rs1 = 0; rs2 = 3;
    check_all("r0_rename");
    chk("r0_qj", 32'(Qj), 32'd0);
    chk("r0_pend", 32'(pending_cnt), 32'd1);

    // Tag 0 rename marks the entry ready
    rename(3, 0);
    check_all("tag0_ready");

    // Asynchronous reset between edges
    rename(6, 9);
    rs1 = 6; rs2 = 6;
    #2 rst_n = 1;
    #1;
    chk("async_qj", 32'(Qj), 32'd0);
    chk("async_qk", 32'(Qk), 32'd0);
    chk("async_pend", 32'(pending_cnt), 32'd0);
    chk("async_rdy", 32'(issue_ready), 32'd0);
    for (int r = 0; r < NR; r++) mdl[r] = 0;

    // A rename held across an edge under reset is discarded
    issue_valid = 1; issue_rd = 8; issue_tag = 9;
    tick();
    rst_n = 0;
    issue_valid = 0; rs1 = 8;
    check_all("rst_discard");
    // First edge after release accepts a rename
    rename(8, 9);
    check_all("rst_release");

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      issue_valid = ($urandom_range(0, 9) < 7);
      issue_rd    = AW'($urandom_range(0, NR - 1));
      issue_tag   = TW'($urandom_range(0, (1 << TW) - 1));
      cdb_valid   = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) != 0) cdb_tag = TW'(mdl[$urandom_range(1, NR - 1)]);
      else cdb_tag = TW'($urandom_range(0, (1 << TW) - 1));
      flush = ($urandom_range(0, 39) == 0);
      rs1   = AW'($urandom_range(0, NR - 1));
      rs2   = ($urandom_range(0, 1) == 1) ? issue_rd : AW'($urandom_range(0, NR - 1));
      check_all("rand");
      tick();
    end
    idle();
    check_all("rand_end");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/reg_status_tbl.md
REG_STATUS_TBL -- requirements
Module: reg_status_tbl

Interface
REQ-001 Parameter NUM_REGS, default 32: number of architectural registers; power of two, at least 2.
REQ-002 Parameter TAG_W, default 4: reservation-station tag width; tag 0 is reserved and means "value valid, no producer".
REQ-003 Parameter BYPASS, default 1: 1 enables same-cycle CDB forwarding on read ports; 0 disables it.
REQ-004 Derived widths: AW = clog2(NUM_REGS); CW = clog2(NUM_REGS+1).
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-high (asserted = 1) despite the name.
REQ-007 issue_valid  in  1  issue stage requests a rename of issue_rd to issue_tag.
REQ-008 issue_ready  out  1  table accepts a rename this cycle.
REQ-009 issue_rd  in  AW  destination register being renamed.
REQ-010 issue_tag  in  TAG_W  producing reservation-station tag.
REQ-011 rs1, rs2  in  AW each  source register indices.
REQ-012 Qj, Qk  out  TAG_W each  producer tag for rs1/rs2; 0 means operand ready.
REQ-013 cdb_valid  in  1  common data bus broadcast valid.
REQ-014 cdb_tag  in  TAG_W  tag completing on the CDB.
REQ-015 flush  in  1  squash all speculative renames.
REQ-016 pending_cnt  out  CW  count of entries with a non-zero tag.

Function
REQ-017 The table SHALL hold NUM_REGS entries of TAG_W bits; entry 0 SHALL always read 0 and never be written.
REQ-018 A rename SHALL occur only when issue_valid && issue_ready at a clk edge; from that edge on, entry[issue_rd] = issue_tag.
REQ-019 issue_ready SHALL equal !flush; it SHALL be combinational and 0 while reset is asserted.
REQ-020 Renaming issue_rd = 0 SHALL be accepted and SHALL have no effect.
REQ-021 issue_tag = 0 SHALL be accepted and SHALL mark the entry ready.
REQ-022 On cdb_valid with cdb_tag != 0, every entry equal to cdb_tag SHALL clear to 0 at the next edge.
REQ-023 cdb_valid with cdb_tag = 0 SHALL be ignored.
REQ-024 If a rename and a matching CDB clear target the same entry in one cycle, the rename SHALL win.
REQ-025 flush SHALL clear all entries to 0 at the next edge; it overrides rename and CDB in the same cycle.
REQ-026 Qj/Qk SHALL be combinational reads of the current table; a same-cycle rename SHALL NOT be visible, so rs1 == issue_rd returns the old tag.
REQ-027 With BYPASS = 1: if cdb_valid, cdb_tag != 0 and the read entry == cdb_tag, the read port SHALL return 0 in that cycle.
REQ-028 With BYPASS = 0: read ports SHALL return the raw entry value.
REQ-029 pending_cnt SHALL be a combinational popcount of non-zero entries in the current table; entry 0 is excluded.
REQ-030 The same tag MAY occupy several entries; a single CDB broadcast SHALL clear all of them.
REQ-031 Latency: table update is 1 cycle; reads have zero latency.

Reset
REQ-032 Asserting rst_n SHALL immediately (asynchronously) clear all entries to 0, giving Qj = Qk = 0 and pending_cnt = 0.
REQ-033 Reset asserted mid-operation SHALL discard any in-flight rename or CDB event in that cycle.
REQ-034 The first rename SHALL be accepted at the first clk edge after rst_n deasserts.

Verification
REQ-035 Reset, then rename r5 to tag 3; next cycle rs1 = 5 -> Qj = 3, pending_cnt = 1.
REQ-036 With r5 = 3 and r9 = 3, send cdb_valid, tag 3 -> the same cycle Qj(rs1 = 9) = 0 (BYPASS = 1); next cycle both entries = 0, pending_cnt = 0.
REQ-037 In the same cycle, rename r7 to 6 and send CDB tag 2 while r7 = 2 -> r7 = 6 afterwards.
REQ-038 Rename r4 to 5 with rs1 = 4 in the same cycle, r4 previously 1 -> Qj = 1 that cycle, then 5.
REQ-039 Fill r1..r31 with non-zero tags, then assert flush together with a rename of r2 to 7 -> issue_ready = 0, all entries 0, pending_cnt = 0.
REQ-040 Rename r0 to 4 -> Qj(rs1 = 0) = 0 and pending_cnt unchanged; assert rst_n asynchronously between edges -> all outputs 0 immediately.
